compare_seq: RTL

COMPARE_SEQ -- requirements
Module: compare_seq

---
 rtl/compare_pkg.sv | 16 +
 rtl/compare_chunk.sv | 26 ++
 rtl/compare_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/compare_pkg.sv
// Shared types and constants for the chunked sequential magnitude comparator.
package compare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Result vector bit order is {less, equal, greater}.
  localparam logic [2:0] RES_NONE    = 3'b000;
  localparam logic [2:0] RES_LESS    = 3'b100;
  localparam logic [2:0] RES_EQUAL   = 3'b010;
  localparam logic [2:0] RES_GREATER = 3'b001;

endpackage

// File: rtl/compare_chunk.sv
// Combinational magnitude compare of one CHUNK-bit slice; exactly one output is high.
module compare_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  // Three-way unsigned compare of the slice.
  always_comb begin
    less    = 1'b0;
    equal   = 1'b0;
    greater = 1'b0;
    if (a < b) begin
      less = 1'b1;
    end else if (a > b) begin
      greater = 1'b1;
    end else begin
      equal = 1'b1;
    end
  end

endmodule

// File: rtl/compare_seq.sv
// Sequential a-vs-b comparator walking CHUNK bits per cycle from the MS chunk down,
// stopping at the first unequal chunk. Define COMPARE_SIGNED_EN to add signed_mode.
module compare_seq
  import compare_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef COMPARE_SIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_MS = IDXW'(NCHUNK - 1);

  generate
    if (CHUNK <= 0 || WIDTH <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("compare_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [2:0]        res_q, res_d;
  logic [WIDTH-1:0]  msb_flip_s;
  logic [CHUNK-1:0]  a_chunk_s, b_chunk_s;
  logic              c_less_s, c_equal_s, c_greater_s;

  // Signed compare becomes unsigned once both sign bits are inverted at capture.
  always_comb begin
    msb_flip_s = '0;
`ifdef COMPARE_SIGNED_EN
    msb_flip_s[WIDTH-1] = signed_mode;
`else
    msb_flip_s[WIDTH-1] = 1'b0;
`endif
  end

  assign a_chunk_s = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign b_chunk_s = b_q[int'(idx_q) * CHUNK +: CHUNK];

  compare_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a       (a_chunk_s),
    .b       (b_chunk_s),
    .less    (c_less_s),
    .equal   (c_equal_s),
    .greater (c_greater_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!c_equal_s || idx_q == '0) state_d = ST_DONE;
        else                           state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_IDLE: begin busy = 1'b0; done = 1'b0; end
      ST_RUN:  begin busy = 1'b1; done = 1'b0; end
      ST_DONE: begin busy = 1'b1; done = 1'b1; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Datapath next values: operand capture, index walk, result latch on completion.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    res_d = res_q;
    if (state_q == ST_IDLE && start) begin
      a_d   = a ^ msb_flip_s;
      b_d   = b ^ msb_flip_s;
      idx_d = IDX_MS;
    end else if (state_q == ST_RUN) begin
      if (c_less_s) begin
        res_d = RES_LESS;
      end else if (c_greater_s) begin
        res_d = RES_GREATER;
      end else if (idx_q == '0) begin
        res_d = RES_EQUAL;
      end else begin
        idx_d = idx_q - {{(IDXW-1){1'b0}}, 1'b1};
      end
    end else begin
      res_d = res_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      res_q <= RES_NONE;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      idx_q <= idx_d;
      res_q <= res_d;
    end
  end

  assign less    = res_q[2];
  assign equal   = res_q[1];
  assign greater = res_q[0];

endmodule
